// File: rtl/rv_pkg.sv
// Shared definitions for the RV64I-subset execute/writeback stage:
// widths, opcode and function-field encodings, stage state and immediate decoders.
package rv_pkg;

    localparam int RV_XLEN     = 64;
    localparam int RV_PC_W     = 32;
    localparam int RV_RETIRE_W = 16;
    localparam int IMM_W       = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } exec_state_e;

    // Immediates are returned sign-extended to 32 bits; callers widen as needed.
    function automatic logic [IMM_W-1:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [IMM_W-1:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'h000};
    endfunction

    function automatic logic [IMM_W-1:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [IMM_W-1:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32 x XLEN integer register file: two operand read ports, one debug read
// port, one write port. x0 always reads zero; all entries clear on reset.
module rv_regfile #(
    parameter int XLEN = 64
) (
    input  logic            clock_1hz,
    input  logic            reset_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] dbg_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs_r [32];

    // Register storage: clear everything on reset, then take one write per edge (x0 never written).
    always_ff @(posedge clock_1hz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Reads are asynchronous, so a same-cycle write is only visible after the edge.
    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs_r[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs_r[rs2_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_r[dbg_addr];

endmodule

// File: rtl/rv_exec_stage.sv
// Execute/writeback stage: decodes the fetched instruction, runs the ALU and
// branch compare, updates the register file, redirects fetch on taken control
// transfers, discards the wrong-path slot, and halts on illegal encodings or
// misaligned targets.
module rv_exec_stage
    import rv_pkg::*;
#(
    parameter int XLEN     = RV_XLEN,
    parameter int PC_W     = RV_PC_W,
    parameter int RETIRE_W = RV_RETIRE_W
) (
    input  logic                clock_1hz,
    input  logic                reset_n,
    input  logic                ir_valid,
    input  logic [31:0]         ir,
    input  logic [PC_W-1:0]     ir_pc,
    output logic                ir_ready,
    output logic                redirect_valid,
    output logic [PC_W-1:0]     redirect_pc,
    output logic                halted,
    input  logic [4:0]          dbg_sel,
    output logic [XLEN-1:0]     dbg_data,
    output logic [RETIRE_W-1:0] retire_count
);

    exec_state_e       state_r;

    logic [6:0]        op_s;
    logic [2:0]        f3_s;
    logic [6:0]        f7_s;
    logic [4:0]        rd_s;
    logic [4:0]        rs1_s;
    logic [4:0]        rs2_s;
    logic [XLEN-1:0]   rs1_data_s;
    logic [XLEN-1:0]   rs2_data_s;
    logic [IMM_W-1:0]  imm_i_s;
    logic [IMM_W-1:0]  imm_u_s;
    logic [IMM_W-1:0]  imm_b_s;
    logic [IMM_W-1:0]  imm_j_s;
    logic [PC_W-1:0]   pc_plus4_s;

    logic              legal_s;
    logic              wr_req_s;
    logic [XLEN-1:0]   wr_data_s;
    logic              taken_s;
    logic [PC_W-1:0]   target_s;

    logic              bubble_s;
    logic              fire_s;
    logic              misalign_s;
    logic              retire_go_s;
    logic              halt_go_s;
    logic              redir_go_s;
    logic              rf_we_s;

    assign op_s  = ir[6:0];
    assign rd_s  = ir[11:7];
    assign f3_s  = ir[14:12];
    assign rs1_s = ir[19:15];
    assign rs2_s = ir[24:20];
    assign f7_s  = ir[31:25];

    assign imm_i_s    = imm_i(ir);
    assign imm_u_s    = imm_u(ir);
    assign imm_b_s    = imm_b(ir);
    assign imm_j_s    = imm_j(ir);
    assign pc_plus4_s = ir_pc + PC_W'(3'd4);

    rv_regfile #(
        .XLEN (XLEN)
    ) u_regfile (
        .clock_1hz (clock_1hz),
        .reset_n   (reset_n),
        .rs1_addr  (rs1_s),
        .rs2_addr  (rs2_s),
        .dbg_addr  (dbg_sel),
        .rs1_data  (rs1_data_s),
        .rs2_data  (rs2_data_s),
        .dbg_data  (dbg_data),
        .wr_en     (rf_we_s),
        .wr_addr   (rd_s),
        .wr_data   (wr_data_s)
    );

    // Decode, ALU result and branch resolution for the instruction presented this cycle.
    always_comb begin
        legal_s   = 1'b0;
        wr_req_s  = 1'b0;
        wr_data_s = '0;
        taken_s   = 1'b0;
        target_s  = ir_pc + imm_b_s[PC_W-1:0];
        case (op_s)
            OP_LUI: begin
                legal_s   = 1'b1;
                wr_req_s  = 1'b1;
                wr_data_s = {{(XLEN-IMM_W){imm_u_s[IMM_W-1]}}, imm_u_s};
            end
            OP_AUIPC: begin
                legal_s   = 1'b1;
                wr_req_s  = 1'b1;
                wr_data_s = {{(XLEN-PC_W){1'b0}}, ir_pc}
                          + {{(XLEN-IMM_W){imm_u_s[IMM_W-1]}}, imm_u_s};
            end
            OP_OPIMM: begin
                if (f3_s == F3_ADD) begin
                    legal_s   = 1'b1;
                    wr_req_s  = 1'b1;
                    wr_data_s = rs1_data_s + {{(XLEN-IMM_W){imm_i_s[IMM_W-1]}}, imm_i_s};
                end else begin
                    legal_s   = 1'b0;
                end
            end
            OP_OP: begin
                if ((f3_s == F3_ADD) && (f7_s == F7_ADD)) begin
                    legal_s   = 1'b1;
                    wr_req_s  = 1'b1;
                    wr_data_s = rs1_data_s + rs2_data_s;
                end else if ((f3_s == F3_ADD) && (f7_s == F7_SUB)) begin
                    legal_s   = 1'b1;
                    wr_req_s  = 1'b1;
                    wr_data_s = rs1_data_s - rs2_data_s;
                end else begin
                    legal_s   = 1'b0;
                end
            end
            OP_JAL: begin
                legal_s   = 1'b1;
                wr_req_s  = 1'b1;
                wr_data_s = {{(XLEN-PC_W){1'b0}}, pc_plus4_s};
                taken_s   = 1'b1;
                target_s  = ir_pc + imm_j_s[PC_W-1:0];
            end
            OP_BRANCH: begin
                if (f3_s == F3_BEQ) begin
                    legal_s = 1'b1;
                    taken_s = (rs1_data_s == rs2_data_s);
                end else if (f3_s == F3_BNE) begin
                    legal_s = 1'b1;
                    taken_s = (rs1_data_s != rs2_data_s);
                end else begin
                    legal_s = 1'b0;
                end
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // Only an accepted, non-bubble instruction in RUN has any architectural effect.
    assign ir_ready    = (state_r != HALT);
    assign bubble_s    = (ir == 32'h0000_0000);
    assign fire_s      = ir_valid && (state_r == RUN) && !bubble_s;
    assign misalign_s  = taken_s && (target_s[1:0] != 2'b00);
    assign halt_go_s   = fire_s && (!legal_s || misalign_s);
    assign retire_go_s = fire_s && legal_s && !misalign_s;
    assign redir_go_s  = retire_go_s && taken_s;
    assign rf_we_s     = retire_go_s && wr_req_s;

    // Stage FSM with its registered outputs: redirect pulse, halt flag, saturating retire counter.
    always_ff @(posedge clock_1hz or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= RUN;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            halted         <= 1'b0;
            retire_count   <= '0;
        end else begin
            redirect_valid <= redir_go_s;
            if (redir_go_s) begin
                redirect_pc <= target_s;
            end
            if (retire_go_s && (retire_count != {RETIRE_W{1'b1}})) begin
                retire_count <= retire_count + RETIRE_W'(1'b1);
            end
            case (state_r)
                RUN: begin
                    if (halt_go_s) begin
                        state_r <= HALT;
                        halted  <= 1'b1;
                    end else if (redir_go_s) begin
                        state_r <= FLUSH;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FLUSH: begin
                    // The wrong-path slot is consumed by the next accepted word, whatever it is.
                    if (ir_valid) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= FLUSH;
                    end
                end
                HALT: begin
                    state_r <= HALT;
                    halted  <= 1'b1;
                end
                default: begin
                    state_r <= HALT;
                    halted  <= 1'b1;
                end
            endcase
        end
    end

endmodule
